// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM scheduler: shares one single-port RAM between the VGA
// scan-out fetch (guaranteed phase-0 slot inside the visible window) and two
// game-logic writers arbitrated round-robin in the remaining slots.
module vga_fb_arbiter #(
   parameter int FB_W    = 320,
   parameter int FB_H    = 240,
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 8,
   parameter int X_START = 145,
   parameter int Y_START = 36
) (
   input  logic              CLOCK_50,
   input  logic              KEY0,
   input  logic              pix_en,
   input  logic [10:0]       x,
   input  logic [10:0]       y,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              err_oob
);

   localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
   localparam logic [10:0] X_END = 11'(X_START + 2 * FB_W);
   localparam logic [10:0] Y_END = 11'(Y_START + 2 * FB_H);

   logic              phase_q, phase_d;
   logic              last_q, last_d;      // 1: writer 1 was granted last
   logic              rd_q, rd_d;          // display read issued last cycle
   logic              blank_q, blank_d;    // out-of-window pixel strobed last cycle
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] pix_q, pix_d;

   logic              cur_phase, in_win, disp_rd, slot;
   logic              w0, w1, oob0, oob1;
   logic [ADDR_W-1:0] row, col, rd_addr;

   // Window test and pixel-doubled read address (row*320 = row*256 + row*64)
   always_comb begin
      in_win  = (x >= 11'(X_START)) && (x < X_END) &&
                (y >= 11'(Y_START)) && (y < Y_END);
      row     = ADDR_W'((y - 11'(Y_START)) >> 1);
      col     = ADDR_W'((x - 11'(X_START)) >> 1);
      rd_addr = (row << 8) + (row << 6) + col;
   end

   // Slot decode, round-robin arbitration and RAM port drive; all gated by
   // KEY0 so a reset kills an in-flight grant within the same cycle
   always_comb begin
      cur_phase = pix_en ? 1'b0 : phase_q;
      disp_rd   = KEY0 & ~cur_phase & in_win;
      slot      = KEY0 & ~disp_rd;
      w1        = slot & req1 & (~req0 | ~last_q);
      w0        = slot & req0 & ~w1;
      oob0      = (addr0 >= FB_SIZE);
      oob1      = (addr1 >= FB_SIZE);

      gnt0      = w0;
      gnt1      = w1;
      mem_we    = (w0 & ~oob0) | (w1 & ~oob1);
      err_oob   = (w0 & oob0) | (w1 & oob1);

      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (disp_rd) begin
         mem_addr = rd_addr;
      end else if (w0) begin
         mem_addr  = addr0;
         mem_wdata = data0;
      end else if (w1) begin
         mem_addr  = addr1;
         mem_wdata = data1;
      end
      pix_data  = pix_q;
   end

   // Next-state: phase toggles, grant history, read-return pipeline
   always_comb begin
      phase_d = ~cur_phase;
      last_d  = w1 ? 1'b1 : (w0 ? 1'b0 : last_q);
      rd_d    = disp_rd;
      blank_d = KEY0 & pix_en & ~in_win;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      pix_d   = pix_q;
      if (rd_q) begin
         pix_d = mem_rdata;
      end else if (blank_q) begin
         pix_d = '0;
      end
   end

   // State registers, cleared asynchronously by KEY0
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         phase_q <= 1'b0;
         last_q  <= 1'b1;
         rd_q    <= 1'b0;
         blank_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         pix_q   <= '0;
      end else begin
         phase_q <= phase_d;
         last_q  <= last_d;
         rd_q    <= rd_d;
         blank_q <= blank_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         pix_q   <= pix_d;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a 1-cycle-latency RAM model.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        KEY0;
   logic        pix_en;
   logic [10:0] x, y;
   logic        req0, req1, gnt0, gnt1;
   logic [16:0] addr0, addr1, mem_addr;
   logic [7:0]  data0, data1, mem_wdata, mem_rdata, pix_data;
   logic        mem_we, err_oob;

   logic        pre_we;
   logic [16:0] pre_addr;
   logic [7:0]  pre_data;
   logic [7:0]  ram [0:(1<<17)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter dut (
      .CLOCK_50 (clk),
      .KEY0     (KEY0),
      .pix_en   (pix_en),
      .x        (x),
      .y        (y),
      .req0     (req0),
      .addr0    (addr0),
      .data0    (data0),
      .gnt0     (gnt0),
      .req1     (req1),
      .addr1    (addr1),
      .data1    (data1),
      .gnt1     (gnt1),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pix_data (pix_data),
      .err_oob  (err_oob)
   );

   // Synchronous RAM: registered read data, bench preload port
   always @(posedge clk) begin
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (mem_we)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic preload(input logic [16:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      nxt();
      pre_we = 1'b0;
   endtask

   initial begin
      bit exp1;
      KEY0 = 1'b0; pix_en = 1'b0; x = '0; y = '0;
      req0 = 1'b1; addr0 = 17'd10; data0 = 8'h11;
      req1 = 1'b1; addr1 = 17'd20; data1 = 8'h21;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      nxt();
      preload(17'd0, 8'h3C);
      preload(17'd321, 8'hA5);
      preload(17'd10267, 8'h77);

      // reset state
      smp();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_oob", err_oob, 0);
      chk("rst_pix", pix_data, 0);

      // release with both requesting: writer 0 first, then strict alternation
      nxt(); KEY0 = 1'b1;
      smp();
      chk("rr1_gnt0", gnt0, 1); chk("rr1_gnt1", gnt1, 0);
      chk("rr1_we", mem_we, 1); chk("rr1_addr", mem_addr, 10);
      nxt(); smp();
      chk("rr2_gnt1", gnt1, 1); chk("rr2_gnt0", gnt0, 0);
      chk("rr2_addr", mem_addr, 20); chk("rr2_wdata", mem_wdata, 8'h21);
      nxt(); smp();
      chk("rr3_gnt0", gnt0, 1); chk("rr3_gnt1", gnt1, 0);

      // idle: no write, address held
      nxt(); req0 = 1'b0; req1 = 1'b0;
      smp();
      chk("idle_we", mem_we, 0); chk("idle_addr", mem_addr, 10);

      // display reads at window origin and (147,38)
      nxt(); pix_en = 1'b1; x = 11'd145; y = 11'd36;
      smp();
      chk("rd0_addr", mem_addr, 0); chk("rd0_we", mem_we, 0);
      nxt(); pix_en = 1'b0;
      nxt(); pix_en = 1'b1; x = 11'd147; y = 11'd38;
      smp();
      chk("rd1_addr", mem_addr, 321); chk("rd0_pix", pix_data, 8'h3C);
      nxt(); pix_en = 1'b0;
      smp();
      chk("rd1_pix_early", pix_data, 8'h3C);
      nxt(); smp();
      chk("rd1_pix", pix_data, 8'hA5);

      // out-of-window pixel: phase-0 slot goes to writer 1, pixel blanked
      nxt(); pix_en = 1'b1; x = 11'd785; y = 11'd100;
      req1 = 1'b1; addr1 = 17'd30; data1 = 8'h31;
      smp();
      chk("oow_gnt1", gnt1, 1); chk("oow_gnt0", gnt0, 0);
      chk("oow_we", mem_we, 1); chk("oow_addr", mem_addr, 30);
      nxt(); pix_en = 1'b0; req1 = 1'b0;
      nxt(); smp();
      chk("oow_pix", pix_data, 0);
      chk("ram30", 32'(ram[30]), 32'h31);

      // out-of-range write address, then the last legal address
      nxt(); x = '0; y = '0; req0 = 1'b1; addr0 = 17'd76800; data0 = 8'h55;
      smp();
      chk("oob_gnt0", gnt0, 1); chk("oob_we", mem_we, 0); chk("oob_err", err_oob, 1);
      nxt(); req0 = 1'b0;
      smp();
      chk("oob_err_clr", err_oob, 0);
      nxt(); req0 = 1'b1; addr0 = 17'd76799; data0 = 8'h66;
      smp();
      chk("max_gnt0", gnt0, 1); chk("max_we", mem_we, 1);
      chk("max_err", err_oob, 0); chk("max_addr", mem_addr, 76799);
      nxt(); req0 = 1'b0;

      // continuous in-window scan with both writers requesting
      x = 11'd200; y = 11'd100;
      req0 = 1'b1; addr0 = 17'd40; data0 = 8'h41;
      req1 = 1'b1; addr1 = 17'd50; data1 = 8'h51;
      for (int i = 0; i < 4; i++) begin
         nxt(); pix_en = 1'b1;
         smp();
         chk("scan_rd_we", mem_we, 0);
         chk("scan_rd_gnt", {gnt1, gnt0}, 0);
         chk("scan_rd_addr", mem_addr, 10267);
         nxt(); pix_en = 1'b0;
         smp();
         exp1 = (i % 2 == 0);
         chk("scan_gnt1", gnt1, exp1);
         chk("scan_gnt0", gnt0, !exp1);
         chk("scan_we", mem_we, 1);
         chk("scan_addr", mem_addr, exp1 ? 32'd50 : 32'd40);
      end

      // reset asserted in the middle of a writer-0 grant
      nxt(); x = '0; y = '0; req1 = 1'b0;
      smp();
      chk("mid_gnt0", gnt0, 1); chk("mid_pix", pix_data, 8'h77);
      #1 KEY0 = 1'b0;
      #1;
      chk("mid_rst_gnt0", gnt0, 0); chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_pix", pix_data, 0);
      nxt(); nxt(); req1 = 1'b1; KEY0 = 1'b1;
      smp();
      chk("post_gnt0", gnt0, 1); chk("post_gnt1", gnt1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
